// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
package mux_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_e;

  localparam int MAX_BURST_DEF = 4;
endpackage

// File: rtl/mux_2_to_1.sv
// Single-bit 2:1 mux cell; s = 1 selects b.
module mux_2_to_1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = s ? b : a;
endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester arbiter with burst-limited round robin feeding a registered output beat.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel
);
  localparam int CW = $clog2(MAX_BURST + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    burst_cnt_q, burst_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] mux_data;
  logic             can_acc, acc, mine_v, other_v, burst_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      last_grant_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  // Output comb: readies only in the matching grant and only when the out register can take a beat
  always_comb begin
    can_acc   = !out_valid_q || out_ready;
    in0_ready = (state_q == GRANT0) && can_acc;
    in1_ready = (state_q == GRANT1) && can_acc;
    case (state_q)
      GRANT0:  sel = 1'b0;
      GRANT1:  sel = 1'b1;
      default: sel = last_grant_q;
    endcase
  end

  assign acc        = (in0_valid && in0_ready) || (in1_valid && in1_ready);
  assign mine_v     = (state_q == GRANT1) ? in1_valid : in0_valid;
  assign other_v    = (state_q == GRANT1) ? in0_valid : in1_valid;
  assign burst_done = (burst_cnt_q + CW'(1)) == CW'(MAX_BURST);

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        if (in0_valid && in1_valid) state_d = last_grant_q ? GRANT0 : GRANT1;
        else if (in0_valid)         state_d = GRANT0;
        else if (in1_valid)         state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (!mine_v) begin
          burst_cnt_d = '0;
          if (other_v) state_d = (state_q == GRANT0) ? GRANT1 : GRANT0;
          else         state_d = IDLE;
        end else if (acc) begin
          if (burst_done) begin
            burst_cnt_d = '0;
            if (other_v) state_d = (state_q == GRANT0) ? GRANT1 : GRANT0;
          end else begin
            burst_cnt_d = burst_cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_d == GRANT0)      last_grant_d = 1'b0;
    else if (state_d == GRANT1) last_grant_d = 1'b1;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux_2_to_1 u_mux (
      .a(in0_data[i]),
      .b(in1_data[i]),
      .s(sel),
      .y(mux_data[i])
    );
  end

  // A simultaneous drain and accept keeps out_valid high for full throughput
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (acc) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized scoreboard bench for mux_rr_arbiter against a behavioural arbitration model.
module tb_mux_rr_arbiter;
  localparam int WIDTH = 8;
  localparam int MAXB  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;
  logic [WIDTH-1:0] in0_data = '0, in1_data = '0;
  logic             in0_ready, in1_ready, out_valid, sel;
  logic [WIDTH-1:0] out_data;

  int vectors = 0;
  int errors  = 0;

  // Model: granted port (-1 = none), beats in current burst, last grant, held output flag
  int m_g, m_cnt, m_last;
  bit m_ov;
  logic [WIDTH-1:0] exp_q[$];

  mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_g = -1; m_cnt = 0; m_last = 1; m_ov = 0;
    exp_q.delete();
  endtask

  // One cycle: drive inputs after the falling edge, compare combinational outputs, advance model
  task automatic cycle(input bit v0, input logic [WIDTH-1:0] d0,
                       input bit v1, input logic [WIDTH-1:0] d1, input bit ordy);
    bit can, r0, r1, mine, other, took;
    int exp_sel;
    @(negedge clk);
    in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1; out_ready = ordy;
    #1;
    can = !m_ov || ordy;
    r0 = (m_g == 0) && can;
    r1 = (m_g == 1) && can;
    exp_sel = (m_g < 0) ? m_last : m_g;
    check("in0_ready", in0_ready, r0);
    check("in1_ready", in1_ready, r1);
    check("sel", sel, exp_sel);
    check("out_valid", out_valid, m_ov);
    took = (v0 && r0) || (v1 && r1);
    if (took) exp_q.push_back(m_g == 0 ? d0 : d1);
    if (m_g < 0) begin
      if (v0 && v1) m_g = 1 - m_last;
      else if (v0)  m_g = 0;
      else if (v1)  m_g = 1;
    end else begin
      mine  = (m_g == 0) ? v0 : v1;
      other = (m_g == 0) ? v1 : v0;
      if (!mine) begin
        m_cnt = 0;
        m_g = other ? 1 - m_g : -1;
      end else if (took) begin
        m_cnt++;
        if (m_cnt == MAXB) begin
          m_cnt = 0;
          if (other) m_g = 1 - m_g;
        end
      end
    end
    if (m_g >= 0) m_last = m_g;
    m_ov = took ? 1'b1 : (ordy ? 1'b0 : m_ov);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst sel", sel, 1);
    check("rst in0_ready", in0_ready, 0);
    check("rst in1_ready", in1_ready, 0);
    model_reset();
    @(negedge clk);
    #3 rst = 1'b0;
  endtask

  // Monitor: each drained beat must be the oldest beat the model predicted
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("out beat unexpected", 1, 0);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    int p0_cnt;
    model_reset();
    repeat (2) @(negedge clk);
    pulse_reset();

    // First grant from reset: port 0 alone
    cycle(1, 8'h11, 0, 8'h00, 1);
    cycle(1, 8'h12, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    // Both ports valid continuously: 4/4 alternation; port tag in data top bit
    for (int i = 0; i < 24; i++) cycle(1, 8'h00 | 8'(i), 1, 8'h80 | 8'(i), 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    // Stall with 0xA5 held, then release
    cycle(1, 8'hA5, 0, 8'h00, 0);
    cycle(1, 8'hA5, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 8'hA6, 0, 8'h00, 0);
      check("stall out_data", out_data, 8'hA5);
    end
    cycle(1, 8'hA6, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    // Port 1 alone for 10 beats
    for (int i = 0; i < 10; i++) cycle(0, 8'h00, 1, 8'h40 + 8'(i), 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);

    // Randomized traffic with varying pressure
    for (int i = 0; i < 3000; i++) begin
      int pv, pr;
      pv = (i < 1500) ? 70 : 40;
      pr = (i % 600 < 300) ? 80 : 35;
      cycle($urandom_range(99) < pv, 8'($urandom), $urandom_range(99) < pv,
            8'($urandom), $urandom_range(99) < pr);
    end

    // Hold 0x3C, reset mid-transfer, then both valid: port 0 wins
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(1, 8'h3C, 0, 8'h00, 0);
    cycle(1, 8'h3C, 0, 8'h00, 0);
    cycle(0, 8'h00, 0, 8'h00, 0);
    check("hold 3C out_data", out_data, 8'h3C);
    pulse_reset();
    cycle(1, 8'h01, 1, 8'h81, 1);
    cycle(1, 8'h02, 1, 8'h82, 1);
    check("post-reset grant port0", in0_ready, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(0, 8'h00, 0, 8'h00, 1);
    check("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
